pwm_decoder: RTL and testbench

Recovers the signed-offset duty command from a motor drive PWM stream (pwm, dir_a, dir_b) and reports it in the same 0..MAX_COUNT midpoint-centred encoding the drive side accepts. It sits on the feedback/loopback path between the H-bridge drive signals and the controller. It is used to verify closed-loop commands and to monitor externally generated drive signals. Inputs are asynchronous; all outputs are registered in the clk domain.

---
 rtl/pwm_decoder.sv | 150 +++++++++++++++
 tb/tb_pwm_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// Decodes an H-bridge PWM stream (pwm, dir_a, dir_b) into a midpoint-centred duty code.
// Optional glitch filter on the synchronized PWM: define PWM_DECODER_FILTER_EN.
module pwm_decoder #(
    parameter int unsigned MAX_COUNT      = 512,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    input  logic        dir_a_in,
    input  logic        dir_b_in,
    output logic [15:0] duty_out,
    output logic [15:0] period_out,
    output logic        duty_valid,
    output logic        stale,
    output logic        fault
);

    localparam logic [15:0] MIDPOINT = 16'(MAX_COUNT >> 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] MAX17    = 17'(MAX_COUNT);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t      state_q;
    logic [1:0]  pwm_sync_q;
    logic [1:0]  dir_a_sync_q;
    logic [1:0]  dir_b_sync_q;
    logic        pwm_prev_q;
    logic [15:0] period_cnt_q;
    logic [15:0] high_cnt_q;
    logic [15:0] to_cnt_q;
    logic [15:0] duty_q;
    logic [15:0] period_q;
    logic        valid_q;
    logic        stale_q;
    logic        fault_q;

    logic        pwm_s;
    logic        dir_a_s;
    logic        dir_b_s;
    logic        rise;
    logic        timeout;
    logic        edge_emit;
    logic        emit;
    logic [15:0] meas_high;
    logic [15:0] meas_period;
    logic [16:0] sum17;
    logic [15:0] duty_d;

    assign dir_a_s = dir_a_sync_q[1];
    assign dir_b_s = dir_b_sync_q[1];

`ifdef PWM_DECODER_FILTER_EN
    // Filtered level follows the synchronizer only once three successive samples agree.
    logic [1:0] pwm_hist_q;
    logic       pwm_filt_q;

    assign pwm_s = (pwm_sync_q[1] == pwm_hist_q[0] && pwm_sync_q[1] == pwm_hist_q[1])
                   ? pwm_sync_q[1] : pwm_filt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_hist_q <= 2'b00;
            pwm_filt_q <= 1'b0;
        end else begin
            pwm_hist_q <= {pwm_hist_q[0], pwm_sync_q[1]};
            pwm_filt_q <= pwm_s;
        end
    end
`else
    assign pwm_s = pwm_sync_q[1];
`endif

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        rise        = pwm_s & ~pwm_prev_q;
        timeout     = !rise && (to_cnt_q == TO_LAST);
        edge_emit   = rise && (state_q == MEASURE);
        emit        = edge_emit | timeout;
        meas_high   = edge_emit ? high_cnt_q : (pwm_s ? MIDPOINT : 16'd0);
        meas_period = edge_emit ? period_cnt_q : 16'd0;
        sum17       = {1'b0, MIDPOINT} + {1'b0, meas_high};
        duty_d      = MIDPOINT;
        if (dir_a_s && !dir_b_s) begin
            duty_d = (sum17 > MAX17) ? MAX17[15:0] : sum17[15:0];
        end else if (dir_b_s && !dir_a_s) begin
            duty_d = (meas_high > MIDPOINT) ? 16'd0 : (MIDPOINT - meas_high);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pwm_sync_q   <= 2'b00;
            dir_a_sync_q <= 2'b00;
            dir_b_sync_q <= 2'b00;
            pwm_prev_q   <= 1'b0;
            period_cnt_q <= 16'd0;
            high_cnt_q   <= 16'd0;
            to_cnt_q     <= 16'd0;
            duty_q       <= MIDPOINT;
            period_q     <= 16'd0;
            valid_q      <= 1'b0;
            stale_q      <= 1'b1;
            fault_q      <= 1'b0;
        end else begin
            pwm_sync_q   <= {pwm_sync_q[0], pwm_in};
            dir_a_sync_q <= {dir_a_sync_q[0], dir_a_in};
            dir_b_sync_q <= {dir_b_sync_q[0], dir_b_in};
            pwm_prev_q   <= pwm_s;
            fault_q      <= dir_a_s & dir_b_s;

            if (rise) begin
                period_cnt_q <= 16'd1;
                high_cnt_q   <= 16'd1;
            end else begin
                if (period_cnt_q != 16'hFFFF) period_cnt_q <= period_cnt_q + 16'd1;
                if (pwm_s && high_cnt_q != MIDPOINT) high_cnt_q <= high_cnt_q + 16'd1;
            end

            if (rise || timeout) to_cnt_q <= 16'd0;
            else                 to_cnt_q <= to_cnt_q + 16'd1;

            valid_q <= emit;
            if (emit) begin
                duty_q   <= duty_d;
                period_q <= meas_period;
            end

            if (edge_emit)    stale_q <= 1'b0;
            else if (timeout) stale_q <= 1'b1;

            // Timeout wins: it can only fire in a cycle without a rise anyway.
            if (timeout)   state_q <= IDLE;
            else if (rise) state_q <= MEASURE;
        end
    end

    assign duty_out   = duty_q;
    assign period_out = period_q;
    assign duty_valid = valid_q;
    assign stale      = stale_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Self-checking bench for pwm_decoder: table-driven PWM vectors plus directed
// sequences for latency, timeout, full scale, fault, reset and (optionally) the filter.
module tb_pwm_decoder;

    localparam int MAX_COUNT = 512;
    localparam int TIMEOUT   = 1024;
`ifdef PWM_DECODER_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in = 1'b0;
    logic        dir_a_in = 1'b0;
    logic        dir_b_in = 1'b0;
    logic [15:0] duty_out;
    logic [15:0] period_out;
    logic        duty_valid;
    logic        stale;
    logic        fault;

    int          checks = 0;
    int          errors = 0;
    int          n_valid = 0;
    logic [15:0] last_duty = '0;
    logic [15:0] last_period = '0;

    pwm_decoder #(.MAX_COUNT(MAX_COUNT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .dir_a_in  (dir_a_in),
        .dir_b_in  (dir_b_in),
        .duty_out  (duty_out),
        .period_out(period_out),
        .duty_valid(duty_valid),
        .stale     (stale),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    // Record every emitted measurement, sampled just after the active edge.
    always begin
        @(posedge clk);
        #1;
        if (duty_valid) begin
            n_valid     = n_valid + 1;
            last_duty   = duty_out;
            last_period = period_out;
        end
    end

    typedef struct {
        int   high;
        int   period;
        logic a;
        logic b;
        int   exp_duty;
        int   exp_period;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_pwm(input int high, input int period, input int nper);
        for (int p = 0; p < nper; p++) begin
            pwm_in = 1'b1;
            repeat (high) @(negedge clk);
            pwm_in = 1'b0;
            repeat (period - high) @(negedge clk);
        end
    endtask

    // Returns the number of edges waited; a missed pulse is reported as a failed check.
    task automatic wait_valid(input string name, input int max_cyc, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!duty_valid && n < max_cyc);
        if (!duty_valid) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_duty"},   int'(duty_out),   MAX_COUNT / 2);
        check({tag, "_period"}, int'(period_out), 0);
        check({tag, "_valid"},  int'(duty_valid), 0);
        check({tag, "_stale"},  int'(stale),      1);
        check({tag, "_fault"},  int'(fault),      0);
    endtask

    initial begin
        int n;
        int n0;

        vecs.push_back('{100, 256, 1'b1, 1'b0, 356, 256});
        vecs.push_back('{ 40, 256, 1'b0, 1'b1, 216, 256});
        vecs.push_back('{ 40, 256, 1'b0, 1'b0, 256, 256});
        vecs.push_back('{100, 256, 1'b1, 1'b1, 256, 256});
        vecs.push_back('{300, 400, 1'b1, 1'b0, 512, 400});
        vecs.push_back('{300, 400, 1'b0, 1'b1,   0, 400});
        vecs.push_back('{255, 256, 1'b1, 1'b0, 511, 256});
        vecs.push_back('{ 20,  50, 1'b0, 1'b1, 236,  50});
`ifndef PWM_DECODER_FILTER_EN
        vecs.push_back('{  1,  10, 1'b1, 1'b0, 257,  10});
`endif

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // First rise after reset only arms the measurement.
        dir_a_in = 1'b1;
        drive_pwm(100, 256, 1);
        check("first_rise_no_emit", n_valid, 0);
        check("stale_before_edge", int'(stale), 1);

        // Second rise: duty_valid exactly LAT edges after pwm goes high, one cycle wide.
        pwm_in = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1;
        check("latency_early", int'(duty_valid), 0);
        @(posedge clk);
        #1;
        check("latency_valid", int'(duty_valid), 1);
        check("latency_duty", int'(duty_out), 356);
        check("latency_period", int'(period_out), 256);
        check("latency_stale", int'(stale), 0);
        @(posedge clk);
        #1;
        check("valid_one_cycle", int'(duty_valid), 0);
        @(negedge clk);
        repeat (100 - LAT - 2) @(negedge clk);
        pwm_in = 1'b0;
        repeat (156) @(negedge clk);

        foreach (vecs[i]) begin
            dir_a_in = vecs[i].a;
            dir_b_in = vecs[i].b;
            drive_pwm(vecs[i].high, vecs[i].period, 3);
            check($sformatf("vec%0d_duty", i), int'(last_duty), vecs[i].exp_duty);
            check($sformatf("vec%0d_period", i), int'(last_period), vecs[i].exp_period);
            check($sformatf("vec%0d_stale", i), int'(stale), 0);
        end

        // Zero drive: static low gives a timeout emit, repeating every TIMEOUT cycles.
        dir_a_in = 1'b0;
        dir_b_in = 1'b0;
        wait_valid("zero_to", TIMEOUT + 100, n);
        check("zero_duty", int'(duty_out), 256);
        check("zero_period", int'(period_out), 0);
        check("zero_stale", int'(stale), 1);
        wait_valid("zero_repeat", TIMEOUT + 100, n);
        check("zero_interval", n, TIMEOUT);
        check("zero_repeat_duty", int'(duty_out), 256);

        // Full scale: pwm held high.
        @(negedge clk);
        dir_a_in = 1'b1;
        pwm_in   = 1'b1;
        wait_valid("fwd_full", TIMEOUT + 100, n);
        check("fwd_full_duty", int'(duty_out), 512);
        check("fwd_full_stale", int'(stale), 1);
        @(negedge clk);
        dir_a_in = 1'b0;
        dir_b_in = 1'b1;
        wait_valid("rev_full", TIMEOUT + 100, n);
        check("rev_full_duty", int'(duty_out), 0);

        // Fault: both directions high.
        @(negedge clk);
        dir_a_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("fault_not_yet", int'(fault), 0);
        @(posedge clk);
        #1;
        check("fault_set", int'(fault), 1);
        wait_valid("fault_emit", TIMEOUT + 100, n);
        check("fault_duty", int'(duty_out), 256);
        @(negedge clk);
        dir_b_in = 1'b0;
        pwm_in   = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("fault_clear", int'(fault), 0);

        // Reset mid-period discards the partial measurement.
        @(negedge clk);
        drive_pwm(100, 256, 2);
        pwm_in = 1'b1;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        n0 = n_valid;
        repeat (49) @(negedge clk);
        pwm_in = 1'b0;
        repeat (156) @(negedge clk);
        check("post_rst_no_emit", n_valid - n0, 0);
        check("post_rst_stale", int'(stale), 1);
        pwm_in = 1'b1;
        wait_valid("post_rst_second", LAT + 2, n);
        check("post_rst_second_stale", int'(stale), 0);
        repeat (100) @(negedge clk);
        pwm_in = 1'b0;
        repeat (156) @(negedge clk);

`ifdef PWM_DECODER_FILTER_EN
        // A 2-cycle glitch in the low phase neither emits nor disturbs the period.
        drive_pwm(100, 256, 1);
        n0 = n_valid;
        pwm_in = 1'b1;
        repeat (100) @(negedge clk);
        pwm_in = 1'b0;
        repeat (50) @(negedge clk);
        pwm_in = 1'b1;
        repeat (2) @(negedge clk);
        pwm_in = 1'b0;
        repeat (104) @(negedge clk);
        drive_pwm(100, 256, 1);
        check("glitch_period", int'(last_period), 256);
        check("glitch_duty", int'(last_duty), 356);
        pwm_in = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_emit_count", n_valid - n0, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
